// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file write port.
// Source 0 has fixed priority; a starvation counter forces a source 1 grant.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s0_valid_i,
    input  logic [4:0]      s0_addr_i,
    input  logic [XLEN-1:0] s0_data_i,
    output logic            s0_ready_o,
    input  logic            s1_valid_i,
    input  logic [4:0]      s1_addr_i,
    input  logic [XLEN-1:0] s1_data_i,
    output logic            s1_ready_o,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            s1_starved_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            forced, gnt0, gnt1;

    assign forced = s1_valid_i && (starve_cnt_q == LIMIT);
    assign gnt1   = s1_valid_i && (forced || !s0_valid_i);
    assign gnt0   = s0_valid_i && !forced;

    assign s0_ready_o   = gnt0;
    assign s1_ready_o   = gnt1;
    assign s1_starved_o = (starve_cnt_q == LIMIT);

    always_comb begin
        starve_cnt_d = '0;
        if (s1_valid_i && !gnt1) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // x0 writes consume the slot but never raise the write enable
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt1) begin
            rf_we_d    = (s1_addr_i != 5'd0);
            rf_waddr_d = s1_addr_i;
            rf_wdata_d = s1_data_i;
        end else if (gnt0) begin
            rf_we_d    = (s0_addr_i != 5'd0);
            rf_waddr_d = s0_addr_i;
            rf_wdata_d = s0_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter against a behavioural writeback model.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s0_valid = 1'b0, s1_valid = 1'b0;
    logic [4:0]      s0_addr = '0, s1_addr = '0;
    logic [XLEN-1:0] s0_data = '0, s1_data = '0;
    logic            s0_ready, s1_ready, rf_we, s1_starved;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    int tests = 0;
    int fails = 0;

    // behavioural model state
    int              lost = 0;
    logic            m_we = 1'b0;
    logic [4:0]      m_waddr = '0;
    logic [XLEN-1:0] m_wdata = '0;
    logic [XLEN-1:0] mem [32];
    logic [XLEN-1:0] dut_mem [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid_i(s0_valid), .s0_addr_i(s0_addr), .s0_data_i(s0_data), .s0_ready_o(s0_ready),
        .s1_valid_i(s1_valid), .s1_addr_i(s1_addr), .s1_data_i(s1_data), .s1_ready_o(s1_ready),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .s1_starved_o(s1_starved)
    );

    // regfile image built from what the DUT actually writes
    always @(posedge clk) if (rf_we) dut_mem[rf_waddr] <= rf_wdata;

    // winner of the current cycle: -1 none, 0 or 1
    function automatic int winner();
        if (s1_valid && lost >= LIMIT) return 1;
        if (s0_valid) return 0;
        if (s1_valid) return 1;
        return -1;
    endfunction

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [XLEN-1:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [XLEN-1:0] d1);
        @(negedge clk);
        s0_valid = v0; s0_addr = a0; s0_data = d0;
        s1_valid = v1; s1_addr = a1; s1_data = d1;
        #1;
    endtask

    task automatic tick();
        int g;
        g = winner();
        @(posedge clk);
        #1;
        if (g == 0) begin
            m_we = (s0_addr != 0); m_waddr = s0_addr; m_wdata = s0_data;
        end else if (g == 1) begin
            m_we = (s1_addr != 0); m_waddr = s1_addr; m_wdata = s1_data;
        end else begin
            m_we = 1'b0;
        end
        if (m_we) mem[m_waddr] = m_wdata;
        if (s1_valid && g != 1) lost = (lost + 1 > LIMIT) ? LIMIT : lost + 1;
        else lost = 0;
    endtask

    task automatic model_reset();
        lost = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, s1_starved, s0_ready, s1_ready} !== '0) begin
            fails++;
            $display("FAIL reset_state: got we=%b addr=%0d data=%h st=%b r0=%b r1=%b required all 0",
                     rf_we, rf_waddr, rf_wdata, s1_starved, s0_ready, s1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_s0_only();
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        tests++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            fails++;
            $display("FAIL s0_only_ready: got r0=%b r1=%b required r0=1 r1=0", s0_ready, s1_ready);
        end
        tick();
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL s0_only_write: got we=%b addr=%0d data=%h required 1/5/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL idle_hold: got we=%b addr=%0d data=%h required 0/5/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 4; c++) begin
            drive(1, 5'(1 + c), 32'(c), 1, 7, 32'h11);
            tests++;
            if (s0_ready !== 1'b1 || s1_ready !== 1'b0 || s1_starved !== 1'b0) begin
                fails++;
                $display("FAIL starve_lose_c%0d: got r0=%b r1=%b st=%b required 1/0/0",
                         c, s0_ready, s1_ready, s1_starved);
            end
            tick();
        end
        drive(1, 9, 32'h99, 1, 7, 32'h11);
        tests++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b1 || s1_starved !== 1'b1) begin
            fails++;
            $display("FAIL starve_forced: got r0=%b r1=%b st=%b required 0/1/1",
                     s0_ready, s1_ready, s1_starved);
        end
        tick();
        tests++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h11) begin
            fails++;
            $display("FAIL starve_write: got we=%b addr=%0d data=%h required 1/7/11",
                     rf_we, rf_waddr, rf_wdata);
        end
        drive(1, 9, 32'h99, 1, 8, 32'h22);
        tests++;
        if (s1_starved !== 1'b0 || s0_ready !== 1'b1) begin
            fails++;
            $display("FAIL starve_cleared: got st=%b r0=%b required 0/1", s1_starved, s0_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 0, 32'hFFFFFFFF);
        tests++;
        if (s1_ready !== 1'b1 || s0_ready !== 1'b0) begin
            fails++;
            $display("FAIL x0_ready: got r1=%b r0=%b required 1/0", s1_ready, s0_ready);
        end
        tick();
        tests++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL x0_write: got we=%b addr=%0d data=%h required 0/0/ffffffff",
                     rf_we, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_same_addr();
        bit s0_done = 0, s1_done = 0;
        int budget = 0;
        logic [XLEN-1:0] seq [$];
        while (!(s0_done && s1_done) && budget < 20) begin
            drive(!s0_done, 3, 32'hA, !s1_done, 3, 32'hB);
            if (s0_ready) s0_done = 1;
            if (s1_ready) s1_done = 1;
            tick();
            if (rf_we && rf_waddr == 5'd3) seq.push_back(rf_wdata);
            budget++;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (seq.size() != 2 || seq[0] !== 32'hA || seq[1] !== 32'hB) begin
            fails++;
            $display("FAIL same_addr_order: got %0d writes first=%h required 2 writes A then B",
                     seq.size(), (seq.size() > 0) ? seq[0] : 32'h0);
        end
        tests++;
        if (dut_mem[3] !== 32'hB || mem[3] !== 32'hB) begin
            fails++;
            $display("FAIL same_addr_final: got %h (model %h) required b", dut_mem[3], mem[3]);
        end
    endtask

    task automatic test_counter_restart();
        for (int c = 0; c < 2; c++) begin drive(1, 4, 32'(c), 1, 6, 32'h66); tick(); end
        drive(1, 4, 32'h5, 0, 0, 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1, 4, 32'(c), 1, 6, 32'h66);
            tests++;
            if (s1_ready !== 1'b0) begin
                fails++;
                $display("FAIL restart_lose_c%0d: got r1=%b required 0", c, s1_ready);
            end
            tick();
        end
        drive(1, 4, 32'h7, 1, 6, 32'h66);
        tests++;
        if (s1_ready !== 1'b1 || s1_starved !== 1'b1) begin
            fails++;
            $display("FAIL restart_forced: got r1=%b st=%b required 1/1", s1_ready, s1_starved);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) begin drive(1, 12, 32'h1234 + c, 1, 13, 32'h55); tick(); end
        tests++;
        if (rf_we !== 1'b1 || lost != 3) begin
            fails++;
            $display("FAIL areset_precond: got we=%b required 1 (model lost=%0d)", rf_we, lost);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, s1_starved} !== '0) begin
            fails++;
            $display("FAIL areset_immediate: got we=%b addr=%0d data=%h st=%b required all 0",
                     rf_we, rf_waddr, rf_wdata, s1_starved);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 12, 32'h77, 1, 13, 32'h55);
        tests++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            fails++;
            $display("FAIL areset_s0_first: got r0=%b r1=%b required 1/0", s0_ready, s1_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        int g;
        bit hold0 = 0, hold1 = 0;
        for (int c = 0; c < 300; c++) begin
            drive(hold0 | ($urandom_range(0, 3) != 0), hold0 ? s0_addr : 5'($urandom),
                  hold0 ? s0_data : $urandom,
                  hold1 | ($urandom_range(0, 2) != 0), hold1 ? s1_addr : 5'($urandom),
                  hold1 ? s1_data : $urandom);
            g = winner();
            tests++;
            if (s0_ready !== (g == 0) || s1_ready !== (g == 1) || s1_starved !== (lost >= LIMIT)) begin
                fails++;
                $display("FAIL rand_ready_c%0d: got r0=%b r1=%b st=%b required winner=%0d st=%0b",
                         c, s0_ready, s1_ready, s1_starved, g, lost >= LIMIT);
            end
            hold0 = s0_valid && g != 0;
            hold1 = s1_valid && g != 1;
            tick();
            tests++;
            if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                fails++;
                $display("FAIL rand_write_c%0d: got we=%b addr=%0d data=%h required %b/%0d/%h",
                         c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        for (int r = 1; r < 32; r++) begin
            tests++;
            if (dut_mem[r] !== mem[r]) begin
                fails++;
                $display("FAIL rand_regfile_x%0d: got %h required %h", r, dut_mem[r], mem[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin mem[r] = '0; dut_mem[r] = '0; end
        test_reset();
        test_s0_only();
        test_starvation();
        test_x0();
        test_same_addr();
        test_counter_restart();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
